// File: rtl/aclint_irq_gate_pkg.sv
// aclint_irq_gate_pkg: cause codes, register offsets and FSM states shared by the
// machine-mode interrupt gate.
package aclint_irq_gate_pkg;
    localparam logic [3:0] IRQ_CAUSE_MEI = 4'd11;
    localparam logic [3:0] IRQ_CAUSE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CAUSE_MTI = 4'd7;
    localparam logic [3:0] IRQG_MIE    = 4'h0;
    localparam logic [3:0] IRQG_MIP    = 4'h4;
    localparam logic [3:0] IRQG_GEN    = 4'h8;
    localparam logic [3:0] IRQG_LCAUSE = 4'hC;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
    // The slave bus carries words with byte 0 as the MSB.
    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction
endpackage

// File: rtl/aclint_irq_gate_sync.sv
// irq_sync: SYNC_STAGES-deep single-bit synchroniser with asynchronous reset to 0.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ff;
    always_ff @(posedge clk or posedge rst)
        if (rst) ff <= '0;
        else     ff <= {ff[SYNC_STAGES-2:0], d};
    assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/aclint_irq_gate.sv
// aclint_irq_gate: masks and prioritises CLINT software/timer and external IRQs and
// presents one latched request to the CPU via a req/ack/mret handshake.
module aclint_irq_gate
    import aclint_irq_gate_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EXT_EDGE    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    input  logic        s_irq,
    input  logic        t_irq,
    input  logic        e_irq,
    output logic        irq_req,
    output logic [3:0]  irq_cause,
    input  logic        irq_ack,
    input  logic        mret
);
    state_t      state;
    logic [2:0]  mie;
    logic        gen, ps, pt, pe_q, e_prev, e_s, pe, pe_set, pe_clr;
    logic [3:0]  lcause, off;
    logic [31:0] wd, rd, mip_word, mie_word;
    logic [2:0]  cand;
    logic [3:0]  cause_sel;
    logic        unused_bits;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(e_irq), .q(e_s));

    assign wd  = bswap(d);
    assign off = {a[3:2], 2'b00};
    assign unused_bits = ^{a[1:0], wd};

    // Level mode passes the synchronised line straight through; edge mode uses the sticky bit.
    assign pe_set = e_s & ~e_prev;
    assign pe_clr = (state == REQ && irq_ack && irq_cause == IRQ_CAUSE_MEI) ||
                    (we && off == IRQG_MIP && wd[11]);
    assign pe     = EXT_EDGE ? pe_q : e_s;

    assign cand      = {pe, pt, ps} & mie & {3{gen}};
    assign cause_sel = cand[2] ? IRQ_CAUSE_MEI : cand[0] ? IRQ_CAUSE_MSI : IRQ_CAUSE_MTI;

    assign mip_word = {20'b0, pe, 3'b0, pt, 3'b0, ps, 3'b0};
    assign mie_word = {20'b0, mie[2], 3'b0, mie[1], 3'b0, mie[0], 3'b0};
    assign rd  = off == IRQG_MIE ? mie_word :
                 off == IRQG_MIP ? mip_word :
                 off == IRQG_GEN ? {31'b0, gen} : {28'b0, lcause};
    assign spo = bswap(rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            irq_req   <= 1'b0;
            irq_cause <= '0;
            lcause    <= '0;
            mie       <= '0;
            gen       <= 1'b0;
            ps        <= 1'b0;
            pt        <= 1'b0;
            pe_q      <= 1'b0;
            e_prev    <= 1'b0;
        end else begin
            ps     <= s_irq;
            pt     <= t_irq;
            e_prev <= e_s;
            pe_q   <= pe_set | (pe_q & ~pe_clr);
            if (we && off == IRQG_MIE) mie <= {wd[11], wd[7], wd[3]};
            if (we && off == IRQG_GEN) gen <= wd[0];
            case (state)
                IDLE: if (|cand) begin
                    irq_cause <= cause_sel;
                    irq_req   <= 1'b1;
                    state     <= REQ;
                end
                REQ: if (irq_ack) begin
                    lcause  <= irq_cause;
                    irq_req <= 1'b0;
                    state   <= SERVICE;
                end
                SERVICE: if (mret) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aclint_irq_gate.sv
// tb_aclint_irq_gate: scenario tasks for a level-mode and an edge-mode gate sharing
// one stimulus bus; expected causes are queued at stimulus time and popped on request.
module tb_aclint_irq_gate;
    logic        clk = 1'b0, rst = 1'b1, we = 1'b0;
    logic [3:0]  a = '0;
    logic [31:0] d = '0;
    logic        s_irq = 1'b0, t_irq = 1'b0, e_irq = 1'b0, irq_ack = 1'b0, mret = 1'b0;
    logic [31:0] spo, spo_e;
    logic        irq_req, irq_req_e;
    logic [3:0]  irq_cause, irq_cause_e;
    int          checks = 0, errors = 0;
    logic [3:0]  exp_q[$];

    always #5 clk = ~clk;

    aclint_irq_gate #(.SYNC_STAGES(2), .EXT_EDGE(1'b0)) dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo), .s_irq(s_irq), .t_irq(t_irq),
        .e_irq(e_irq), .irq_req(irq_req), .irq_cause(irq_cause), .irq_ack(irq_ack), .mret(mret));
    aclint_irq_gate #(.SYNC_STAGES(2), .EXT_EDGE(1'b1)) dut_e (
        .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo_e), .s_irq(s_irq), .t_irq(t_irq),
        .e_irq(e_irq), .irq_req(irq_req_e), .irq_cause(irq_cause_e), .irq_ack(irq_ack), .mret(mret));

    function automatic logic [31:0] sw(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] ad, input logic [31:0] v);
        a = ad; d = sw(v); we = 1'b1;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] ad, output logic [31:0] v, output logic [31:0] ve);
        a = ad;
        #1;
        v = sw(spo); ve = sw(spo_e);
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1; cyc(); mret = 1'b0;
    endtask

    // Returns the number of falling edges until the request is seen, -1 on timeout.
    task automatic wait_req(input bit edge_dut, output int n);
        n = -1;
        for (int i = 0; i <= 20; i++) begin
            if ((edge_dut ? irq_req_e : irq_req) === 1'b1) begin n = i; break; end
            cyc();
        end
    endtask

    task automatic test_reset();
        logic [31:0] v, ve;
        rst = 1'b1; cyc(2); rst = 1'b0; cyc();
        for (int i = 0; i < 4; i++) begin
            rd(4'(i * 4), v, ve);
            checks++;
            if (v !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", i, v); end
        end
        checks++;
        if (irq_req !== 1'b0 || irq_cause !== 4'd0) begin
            errors++; $display("FAIL reset_out got req=%b cause=%0d exp req=0 cause=0", irq_req, irq_cause);
        end
    endtask

    task automatic test_timer();
        logic [31:0] v, ve;
        logic [3:0]  e;
        wr(4'h0, 32'h80); wr(4'h8, 32'h1);
        t_irq = 1'b1; exp_q.push_back(4'd7);
        cyc(); t_irq = 1'b0;
        checks++;
        if (irq_req !== 1'b0) begin errors++; $display("FAIL timer_early got %b exp 0", irq_req); end
        cyc();
        checks++;
        if (irq_req !== 1'b1) begin errors++; $display("FAIL timer_latency got %b exp 1", irq_req); end
        e = exp_q.pop_front();
        checks++;
        if (irq_cause !== e) begin errors++; $display("FAIL timer_cause got %0d exp %0d", irq_cause, e); end
        pulse_ack();
        rd(4'hC, v, ve);
        checks++;
        if (irq_req !== 1'b0 || v !== 32'd7) begin
            errors++; $display("FAIL timer_ack got req=%b lcause=%0d exp req=0 lcause=7", irq_req, v);
        end
        pulse_mret(); cyc(3);
        checks++;
        if (irq_req !== 1'b0) begin errors++; $display("FAIL timer_idle got %b exp 0", irq_req); end
    endtask

    task automatic test_priority();
        logic [31:0] v, ve;
        logic [3:0]  e;
        int          n;
        wr(4'h0, 32'h888);
        s_irq = 1'b1; t_irq = 1'b1; e_irq = 1'b1;
        exp_q.push_back(4'd3); exp_q.push_back(4'd11); exp_q.push_back(4'd3); exp_q.push_back(4'd7);
        wait_req(1'b0, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL prio_latency got %0d exp 2", n); end
        e = exp_q.pop_front();
        checks++;
        if (irq_cause !== e) begin errors++; $display("FAIL prio_first got %0d exp %0d", irq_cause, e); end
        pulse_ack(); pulse_mret();
        wait_req(1'b0, n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL prio_after_mret got %0d exp 1", n); end
        e = exp_q.pop_front();
        checks++;
        if (irq_cause !== e) begin errors++; $display("FAIL prio_ext got %0d exp %0d", irq_cause, e); end
        pulse_ack();
        rd(4'hC, v, ve);
        checks++;
        if (v !== 32'd11) begin errors++; $display("FAIL prio_lcause got %0d exp 11", v); end
        e_irq = 1'b0; cyc(3); pulse_mret();
        wait_req(1'b0, n);
        e = exp_q.pop_front();
        checks++;
        if (irq_cause !== e || n < 0) begin errors++; $display("FAIL prio_sw_again got %0d exp %0d", irq_cause, e); end
        pulse_ack(); s_irq = 1'b0; cyc(2); pulse_mret();
        wait_req(1'b0, n);
        e = exp_q.pop_front();
        checks++;
        if (irq_cause !== e || n < 0) begin errors++; $display("FAIL prio_timer got %0d exp %0d", irq_cause, e); end
        pulse_ack(); t_irq = 1'b0; cyc(); pulse_mret(); cyc(3);
    endtask

    task automatic test_edge();
        logic [31:0] v, ve;
        logic [3:0]  e;
        int          n;
        rst = 1'b1; cyc(); rst = 1'b0;
        e_irq = 1'b1; cyc(); e_irq = 1'b0; cyc(5);
        rd(4'h4, v, ve);
        checks++;
        if (ve !== 32'h800 || v !== 32'h0) begin
            errors++; $display("FAIL edge_latched got edge=%h level=%h exp 800/0", ve, v);
        end
        checks++;
        if (irq_req_e !== 1'b0) begin errors++; $display("FAIL edge_masked got %b exp 0", irq_req_e); end
        wr(4'h0, 32'h800); wr(4'h8, 32'h1);
        exp_q.push_back(4'd11);
        wait_req(1'b1, n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL edge_enable_latency got %0d exp 1", n); end
        e = exp_q.pop_front();
        checks++;
        if (irq_cause_e !== e) begin errors++; $display("FAIL edge_cause got %0d exp %0d", irq_cause_e, e); end
        pulse_ack();
        rd(4'h4, v, ve);
        checks++;
        if (ve !== 32'h0) begin errors++; $display("FAIL edge_ack_clear got %h exp 0", ve); end
        wr(4'h0, 32'h0);
        e_irq = 1'b1; cyc(); e_irq = 1'b0; cyc(5);
        rd(4'h4, v, ve);
        checks++;
        if (ve !== 32'h800) begin errors++; $display("FAIL edge_relatch got %h exp 800", ve); end
        wr(4'h4, 32'h800);
        rd(4'h4, v, ve);
        checks++;
        if (ve !== 32'h0) begin errors++; $display("FAIL edge_w1c got %h exp 0", ve); end
    endtask

    task automatic test_freeze();
        logic [31:0] v, ve;
        logic [3:0]  e;
        int          n;
        rst = 1'b1; cyc(); rst = 1'b0;
        wr(4'h0, 32'h80); wr(4'h8, 32'h1);
        t_irq = 1'b1; exp_q.push_back(4'd7);
        wait_req(1'b0, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== 2 || irq_cause !== e) begin
            errors++; $display("FAIL freeze_req got n=%0d cause=%0d exp n=2 cause=%0d", n, irq_cause, e);
        end
        wr(4'h0, 32'h0); t_irq = 1'b0; cyc(3);
        checks++;
        if (irq_req !== 1'b1 || irq_cause !== 4'd7) begin
            errors++; $display("FAIL freeze_hold got req=%b cause=%0d exp req=1 cause=7", irq_req, irq_cause);
        end
        pulse_mret(); cyc();
        checks++;
        if (irq_req !== 1'b1) begin errors++; $display("FAIL freeze_mret_ignored got %b exp 1", irq_req); end
        pulse_ack();
        rd(4'hC, v, ve);
        checks++;
        if (irq_req !== 1'b0 || v !== 32'd7) begin
            errors++; $display("FAIL freeze_ack got req=%b lcause=%0d exp req=0 lcause=7", irq_req, v);
        end
        pulse_mret(); cyc(3);
        checks++;
        if (irq_req !== 1'b0) begin errors++; $display("FAIL freeze_no_candidate got %b exp 0", irq_req); end
    endtask

    task automatic test_async_reset();
        logic [31:0] v, ve;
        logic [3:0]  e;
        int          n;
        wr(4'h0, 32'h80); wr(4'h8, 32'h1);
        t_irq = 1'b1; exp_q.push_back(4'd7);
        wait_req(1'b0, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== 2 || irq_cause !== e) begin
            errors++; $display("FAIL areset_setup got n=%0d cause=%0d exp n=2 cause=%0d", n, irq_cause, e);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (irq_req !== 1'b0 || irq_cause !== 4'd0) begin
            errors++; $display("FAIL areset_req_drop got req=%b cause=%0d exp 0/0", irq_req, irq_cause);
        end
        cyc(); rst = 1'b0; t_irq = 1'b0;
        wr(4'h0, 32'h80); wr(4'h8, 32'h1);
        t_irq = 1'b1; exp_q.push_back(4'd7);
        wait_req(1'b0, n);
        e = exp_q.pop_front();
        pulse_ack(); t_irq = 1'b0;
        checks++;
        if (irq_req !== 1'b0 || n !== 2 || irq_cause !== e) begin
            errors++; $display("FAIL areset_service got req=%b n=%0d cause=%0d exp 0/2/%0d", irq_req, n, irq_cause, e);
        end
        cyc();
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(4'(i * 4), v, ve);
            checks++;
            if (v !== 32'h0) begin errors++; $display("FAIL areset_reg%0d got %h exp 0", i, v); end
        end
        cyc(); rst = 1'b0;
        pulse_ack(); cyc();
        rd(4'hC, v, ve);
        checks++;
        if (irq_req !== 1'b0 || v !== 32'h0) begin
            errors++; $display("FAIL areset_stray_ack got req=%b lcause=%0d exp 0/0", irq_req, v);
        end
        wr(4'h0, 32'h80); wr(4'h8, 32'h1);
        t_irq = 1'b1; exp_q.push_back(4'd7);
        wait_req(1'b0, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== 2 || irq_cause !== e) begin
            errors++; $display("FAIL areset_idle got n=%0d cause=%0d exp n=2 cause=%0d", n, irq_cause, e);
        end
        t_irq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timer();
        test_priority();
        test_edge();
        test_freeze();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end
endmodule
